// File: rtl/mux_4a1_lanes.sv
// mux_4a1_lanes: four-lane to one-byte serializer.
//
// Snapshots four lane bytes and their valid flags once every four clocks, on
// the edge where phase == 3, then replays the snapshot one lane per clock in
// fixed lane order 0,1,2,3. Invalid lanes still take their slot, so lanes are
// never compacted and lane_out always cycles 0..3.
//
// Optional feature macro: MUX_IDLE_SYM_EN
//   defined     - invalid slots drive data_out = IDLE_SYM
//   not defined - invalid slots drive data_out with the stored snapshot byte
//                 (0 after reset); consumers must qualify with valid_out.
// valid_out, lane_out, frame_start and valid_count do not depend on the macro.

module mux_4a1_lanes #(
  parameter int            BW       = 8,
  parameter logic [BW-1:0] IDLE_SYM = BW'(8'hBC)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [BW-1:0] data_in0,
  input  logic [BW-1:0] data_in1,
  input  logic [BW-1:0] data_in2,
  input  logic [BW-1:0] data_in3,
  input  logic          valid_in0,
  input  logic          valid_in1,
  input  logic          valid_in2,
  input  logic          valid_in3,
  output logic [BW-1:0] data_out,
  output logic          valid_out,
  output logic [1:0]    lane_out,
  output logic          frame_start,
  output logic [2:0]    valid_count
);

  localparam int         LANES       = 4;
  localparam logic [1:0] CAPTURE_PH  = 2'd3;
  localparam logic [1:0] FRAME_PH    = 2'd0;

  // Slot counter: selects the snapshot lane presented on the next edge.
  logic [1:0]    phase;

  // Snapshot of one 4-cycle window.
  logic [BW-1:0] snap_data [LANES];
  logic [3:0]    snap_valid;

  // Lane inputs gathered into indexable form.
  logic [BW-1:0] lane_data  [LANES];
  logic [3:0]    lane_valid;

  // Values selected for the current slot.
  logic [BW-1:0] slot_byte;
  logic          slot_valid;
  logic          capture;

  assign lane_data[0] = data_in0;
  assign lane_data[1] = data_in1;
  assign lane_data[2] = data_in2;
  assign lane_data[3] = data_in3;
  assign lane_valid   = {valid_in3, valid_in2, valid_in1, valid_in0};

  // The window boundary: last slot of the old snapshot goes out on this edge
  // while the new snapshot is loaded.
  assign capture = (phase == CAPTURE_PH);

  // Number of set bits in a 4-bit valid vector (0..4).
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < LANES; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

  // Select the byte and qualifier for the slot addressed by phase.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    slot_byte  = snap_data[phase];
    slot_valid = snap_valid[phase];
`ifdef MUX_IDLE_SYM_EN
    if (!slot_valid) begin
      slot_byte = IDLE_SYM;
    end
`endif
  end

  // Phase counter, snapshot capture and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase       <= 2'd0;
      // NOTE: the snapshot is a handful of flops, not a RAM, so it is cleared
      // on reset; a window in flight at reset must never be replayed.
      for (int i = 0; i < LANES; i++) begin
        snap_data[i] <= '0;
      end
      snap_valid  <= 4'd0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      lane_out    <= 2'd0;
      frame_start <= 1'b0;
      valid_count <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments make the output stage read the old
      // snapshot lane 3 on the capture edge while the new snapshot loads, so
      // nothing is lost or duplicated at the window boundary.
      phase       <= phase + 2'd1;
      data_out    <= slot_byte;
      valid_out   <= slot_valid;
      lane_out    <= phase;
      frame_start <= (phase == FRAME_PH);
      if (capture) begin
        for (int i = 0; i < LANES; i++) begin
          snap_data[i] <= lane_data[i];
        end
        snap_valid  <= lane_valid;
        valid_count <= popcount4(lane_valid);
      end
    end
  end

endmodule
